ppu_oam_dma: RTL and testbench
==============================

// Module: ppu_oam_dma
// PURPOSE
// - Sprite DMA controller ($4014) that sequences CPU-bus reads into PPU primary OAM.
// - On a CPU write of page P to $4014 it halts the CPU and copies CPU $PP00-$PPFF (BYTES bytes) into OAM.
// - OAM writes start at the current OAMADDR and wrap modulo 256.
// - oam_dma drives the sprite unit's OAM address/write-enable mux for the whole transfer.
// PARAMETERS
// - BYTES     256  bytes per transfer (1..256); byte counter is 9 bits
// - ALIGN_EN  1    1 = insert alignment cycle when halt lands on a put cycle (513/514 timing); 0 = never
// PORTS
// - clk          in   1   system clock
// - reset        in   1   asynchronous, active-high reset
// - cpu_ce       in   1   one-clk pulse per CPU cycle; all state advances only when cpu_ce=1
// - reg_wr       in   1   CPU write strobe to $4014 (qualified by cpu_ce)
// - reg_data     in   8   page number P written to $4014
// - oamaddr_in   in   8   current OAMADDR ($2003) value
// - cpu_rd_data  in   8   CPU bus read data for dma_addr, valid at the cpu_ce edge ending a READ
// - cpu_halt     out  1   CPU RDY deassert; 1 while transfer is pending/active
// - dma_addr     out  16  CPU bus address {P, byte_cnt[7:0]}
// - dma_rd       out  1   CPU bus read request (state READ)
// - oam_dma      out  1   busy; selects DMA path into OAM
// - oam_addr     out  8   OAM write address
// - oam_data     out  8   OAM write data
// - oam_we       out  1   OAM write enable, = (state==WRITE) & cpu_ce
// - dma_done     out  1   one-clk pulse on the cpu_ce edge completing the last WRITE
// BEHAVIOUR
// - Reset: state=IDLE, parity=0.
// - Reset value of every output is 0; dma_addr=16'h0000, oam_addr=8'h00, oam_data=8'h00.
// - Parity flag toggles on every cpu_ce: 0 = get cycle, 1 = put cycle; it runs continuously, including in IDLE.
// - States IDLE, HALT, ALIGN, READ, WRITE; all transitions happen only on clk edges where cpu_ce=1.
// - IDLE: reg_wr&cpu_ce -> latch P and oam_base=oamaddr_in, byte_cnt=0 -> HALT; cpu_halt=1 from next clk.
// - HALT: one dummy CPU cycle. If ALIGN_EN and the next cycle is a put cycle (parity==0 now) -> ALIGN, else -> READ.
// - ALIGN: one dummy cycle -> READ.
// - READ: dma_rd=1, dma_addr={P,byte_cnt[7:0]}; on cpu_ce latch oam_data<=cpu_rd_data -> WRITE.
// - WRITE: oam_addr=oam_base+byte_cnt[7:0] (8-bit wrap); oam_we pulses with cpu_ce; byte_cnt++.
// - WRITE exit: if byte_cnt==BYTES-1 -> IDLE with dma_done=1, else -> READ.
// - Total halt = 1 + align + 2*BYTES CPU cycles; with BYTES=256 this is 513 or 514.
// - cpu_halt deasserts on the same clk edge as dma_done; IDLE is entered on that edge.
// - oam_dma=1 in every non-IDLE state.
// - reg_wr while not IDLE is ignored; P and oam_base are unchanged.
// - oamaddr_in changes mid-transfer are ignored; only the value latched at start is used.
// - cpu_ce low: all state, counters and outputs hold; oam_we=0.
// - Reset asserted mid-transfer: immediate abort to IDLE, all outputs 0, no further OAM writes.
// - Back-to-back: a reg_wr on the cpu_ce cycle after dma_done starts a new transfer normally.
// TESTING
// - T1: P=0x02, oamaddr=0, write on get cycle (parity 0) -> HALT, READ; 513 halt cycles.
// - T1 (cont.): OAM[i]=mem[0x0200+i] for i=0..255; exactly 256 oam_we pulses; one dma_done.
// - T2: same write issued on put cycle -> ALIGN inserted; cpu_halt high for exactly 514 cpu_ce cycles.
// - T3: oamaddr_in=0xF8, P=0x03 -> mem[0x0300] lands in OAM[0xF8].
// - T3 (cont.): mem[0x0308] lands in OAM[0x00]; last write is to OAM[0xF7].
// - T4: second reg_wr (P=0x07) at byte 100 -> ignored; dma_addr stays 0x03xx through completion.
// - T5: reset at byte 50 -> cpu_halt=0, oam_dma=0, oam_we=0 same cycle.
// - T5 (cont.): no further OAM writes; a new write after reset completes normally.
// - T6: cpu_ce held low 5 clks during READ -> dma_addr/oam_data/state frozen, oam_we=0.
// - T6 (cont.): transfer resumes and finishes with identical OAM contents.

Source files
------------

// File: rtl/ppu_oam_dma_if.sv
// ppu_oam_dma_if: CPU-bus / OAM-side signal bundle for the sprite DMA unit.
//   master : the DMA controller (drives halt, bus read request, OAM write port)
//   slave  : the surrounding system (drives CPU clock enable, $4014 write,
//            OAMADDR value and CPU bus read data)
interface ppu_oam_dma_if;
  logic        cpu_ce;       // one-clk pulse per CPU cycle
  logic        reg_wr;       // $4014 write strobe
  logic [7:0]  reg_data;     // page number written to $4014
  logic [7:0]  oamaddr_in;   // current OAMADDR
  logic [7:0]  cpu_rd_data;  // CPU bus read data for dma_addr
  logic        cpu_halt;     // CPU RDY deassert
  logic [15:0] dma_addr;     // CPU bus read address
  logic        dma_rd;       // CPU bus read request
  logic        oam_dma;      // DMA owns the OAM port
  logic [7:0]  oam_addr;     // OAM write address
  logic [7:0]  oam_data;     // OAM write data
  logic        oam_we;       // OAM write enable
  logic        dma_done;     // transfer-complete pulse

  modport master (
    input  cpu_ce, reg_wr, reg_data, oamaddr_in, cpu_rd_data,
    output cpu_halt, dma_addr, dma_rd, oam_dma, oam_addr, oam_data, oam_we, dma_done
  );

  modport slave (
    output cpu_ce, reg_wr, reg_data, oamaddr_in, cpu_rd_data,
    input  cpu_halt, dma_addr, dma_rd, oam_dma, oam_addr, oam_data, oam_we, dma_done
  );
endinterface

// File: rtl/ppu_oam_dma.sv
// ppu_oam_dma: $4014 sprite DMA controller. A CPU write of page P halts the
// CPU and copies CPU $PP00.. (BYTES bytes) into primary OAM, starting at the
// OAMADDR value captured at the write and wrapping modulo 256.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : ppu_oam_dma_if.master (CPU enable, $4014 write, OAMADDR,
//                CPU read data in; halt, bus read, OAM write port, done out)
// Every state change is gated by bus.cpu_ce so the unit runs at CPU rate.
module ppu_oam_dma #(
  parameter int BYTES    = 256,
  parameter bit ALIGN_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  ppu_oam_dma_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE
  } state_e;

  localparam logic [8:0] LAST = 9'(BYTES - 1);

  state_e      state_q, state_d;
  logic        parity_q, parity_d;   // 0 = get cycle, 1 = put cycle
  logic [7:0]  page_q, page_d;
  logic [7:0]  base_q, base_d;       // OAMADDR captured at start
  logic [7:0]  data_q, data_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      page_q   <= '0;
      base_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      page_q   <= page_d;
      base_q   <= base_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    parity_d = parity_q;
    page_d   = page_q;
    base_d   = base_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;               // single-clk pulse regardless of cpu_ce
    if (bus.cpu_ce) begin
      parity_d = ~parity_q;        // free-running, even in IDLE
      case (state_q)
        S_IDLE: begin
          if (bus.reg_wr) begin
            page_d  = bus.reg_data;
            base_d  = bus.oamaddr_in;
            cnt_d   = '0;
            state_d = S_HALT;
          end
        end
        // parity_q==0 now means the following cycle is a put cycle; a read
        // must land on a get cycle, so burn one extra cycle to align.
        S_HALT:  state_d = (ALIGN_EN && !parity_q) ? S_ALIGN : S_READ;
        S_ALIGN: state_d = S_READ;
        S_READ: begin
          data_d  = bus.cpu_rd_data;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.cpu_halt = (state_q != S_IDLE);
  assign bus.oam_dma  = (state_q != S_IDLE);
  assign bus.dma_rd   = (state_q == S_READ);
  assign bus.dma_addr = {page_q, cnt_q[7:0]};
  assign bus.oam_addr = base_q + cnt_q[7:0];   // 8-bit wrap
  assign bus.oam_data = data_q;
  assign bus.oam_we   = (state_q == S_WRITE) && bus.cpu_ce;
  assign bus.dma_done = done_q;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// tb_ppu_oam_dma: table-driven transfers with random cpu_ce gaps, checked
// against a reference model that expands each $4014 write into the list of
// OAM writes it must produce and the number of halted CPU cycles.
module tb_ppu_oam_dma;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ppu_oam_dma_if bus ();

  ppu_oam_dma #(.BYTES(256), .ALIGN_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [7:0] mem [65536];
  logic [7:0] oam [256];
  assign bus.cpu_rd_data = mem[bus.dma_addr];

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct {
    logic [7:0] page;
    logic [7:0] oa;
    int         par;       // required parity at the write, -1 = whatever it is
    int         act_at;    // writes completed before the mid-transfer action
    int         act_kind;  // 0 none, 1 second $4014 write, 2 reset, 3 ce stall
    int         exp_halt;  // expected halted CPU cycles, -1 = derive from parity
  } vec_t;

  wr_t        expq[$];
  bit         par;
  bit         mbusy;
  bit         m_put;
  logic [7:0] m_page;
  logic [7:0] last_addr;
  int         halt_cnt, we_cnt, done_cnt;
  int         checks = 0;
  int         errors = 0;
  vec_t       tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clk: drive at negedge, check combinational outputs before the edge,
  // registered outputs after it. Returns at the following negedge.
  task automatic step(input bit ce, input bit wr, input logic [7:0] d, input logic [7:0] oa);
    bit last_pop;
    wr_t e;
    last_pop = 1'b0;
    bus.cpu_ce = ce; bus.reg_wr = wr; bus.reg_data = d; bus.oamaddr_in = oa;
    #2;
    if (!ce) chk("we_ce_low", bus.oam_we, 0);
    if (expq.size() == 0) chk("no_we", bus.oam_we, 0);
    else if (bus.oam_we) begin
      e = expq.pop_front();
      chk("we_addr", bus.oam_addr, e.addr);
      chk("we_data", bus.oam_data, e.data);
      oam[bus.oam_addr] = bus.oam_data;
      last_addr = bus.oam_addr;
      we_cnt++;
      last_pop = (expq.size() == 0);
    end
    if (ce && bus.dma_rd)
      chk("rd_addr", bus.dma_addr, {m_page, 8'(256 - expq.size())});
    if (ce && bus.cpu_halt) halt_cnt++;
    if (ce && wr && !mbusy) begin
      mbusy = 1'b1; m_put = par; m_page = d;
      halt_cnt = 0; we_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 256; i++)
        expq.push_back('{addr: oa + 8'(i), data: mem[{d, 8'(i)}]});
    end
    if (ce) par = ~par;
    @(negedge clk);
    if (last_pop) mbusy = 1'b0;
    if (bus.dma_done) done_cnt++;
    chk("dma_done", bus.dma_done, last_pop);
    chk("cpu_halt", bus.cpu_halt, mbusy);
    chk("oam_dma", bus.oam_dma, mbusy);
  endtask

  task automatic do_reset();
    bus.cpu_ce = 1'b1; bus.reg_wr = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_halt", bus.cpu_halt, 0);
    chk("rst_dma", bus.oam_dma, 0);
    chk("rst_we", bus.oam_we, 0);
    chk("rst_rd", bus.dma_rd, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.cpu_ce = 1'b0;
    expq.delete(); mbusy = 1'b0; par = 1'b0;
  endtask

  task automatic xfer(input vec_t v);
    int  n, nmis, exp_h;
    bit  acted, aborted;
    acted = 1'b0; aborted = 1'b0;
    if (v.par >= 0) while (par != bit'(v.par)) step(1'b1, 1'b0, 8'h00, 8'($urandom));
    step(1'b1, 1'b1, v.page, v.oa);
    exp_h = (v.exp_halt >= 0) ? v.exp_halt : 513 + int'(m_put);
    n = 0;
    while (mbusy && n < 3000) begin
      step($urandom_range(0, 3) != 0, 1'b0, 8'($urandom), 8'($urandom));
      n++;
      if (!acted && v.act_at >= 0 && (256 - expq.size()) == v.act_at) begin
        acted = 1'b1;
        case (v.act_kind)
          1: step(1'b1, 1'b1, 8'h07, 8'h55);
          2: begin
            step(1'b1, 1'b0, 8'h00, 8'h00);   // READ -> WRITE
            do_reset();
            for (int k = 0; k < 20; k++) step($urandom_range(0, 1) == 1, 1'b0, 8'h00, 8'h00);
            chk("post_rst_we", we_cnt, 50);
            aborted = 1'b1;
          end
          3: begin
            chk("stall_rd0", bus.dma_rd, 1);
            for (int k = 0; k < 5; k++) begin
              step(1'b0, 1'b0, 8'h00, 8'($urandom));
              chk("stall_addr", bus.dma_addr, {m_page, 8'(v.act_at)});
              chk("stall_rd", bus.dma_rd, 1);
            end
          end
          default: ;
        endcase
      end
    end
    if (aborted) return;
    chk("xfer_timeout", mbusy, 0);
    if (mbusy) begin do_reset(); return; end
    chk("halt_cyc", halt_cnt, exp_h);
    chk("we_cnt", we_cnt, 256);
    chk("done_cnt", done_cnt, 1);
    nmis = 0;
    for (int i = 0; i < 256; i++)
      if (oam[8'(v.oa + 8'(i))] !== mem[{v.page, 8'(i)}]) nmis++;
    chk("oam_img", nmis, 0);
  endtask

  initial begin
    bus.cpu_ce = 1'b0; bus.reg_wr = 1'b0; bus.reg_data = '0; bus.oamaddr_in = '0;
    reset = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) oam[i] = '0;
    par = 1'b0; mbusy = 1'b0; m_page = '0; m_put = 1'b0; last_addr = '0;
    halt_cnt = 0; we_cnt = 0; done_cnt = 0;

    //            page   oa     par act kind halt
    tbl[0] = '{8'h02, 8'h00,  0, -1, 0, 513};  // get-cycle write
    tbl[1] = '{8'h02, 8'h00,  1, -1, 0, 514};  // put-cycle write, align
    tbl[2] = '{8'h03, 8'hF8,  0, -1, 0, 513};  // OAMADDR wrap
    tbl[3] = '{8'h03, 8'h10,  0, 100, 1, 513}; // ignored second write
    tbl[4] = '{8'h04, 8'h20,  1, 50, 2, -1};   // reset mid-transfer
    tbl[5] = '{8'h05, 8'h00,  0, -1, 0, 513};  // clean run after reset
    tbl[6] = '{8'h06, 8'h40,  1, 7, 3, 514};   // cpu_ce stall in READ
    tbl[7] = '{8'($urandom), 8'($urandom), -1, -1, 0, -1}; // back-to-back
    tbl[8] = '{8'($urandom), 8'($urandom),  0, -1, 0, 513};
    tbl[9] = '{8'($urandom), 8'($urandom),  1, -1, 0, 514};

    @(negedge clk);
    @(negedge clk);
    chk("r_halt", bus.cpu_halt, 0);
    chk("r_addr", bus.dma_addr, 16'h0000);
    chk("r_rd", bus.dma_rd, 0);
    chk("r_dma", bus.oam_dma, 0);
    chk("r_oaddr", bus.oam_addr, 8'h00);
    chk("r_odata", bus.oam_data, 8'h00);
    chk("r_we", bus.oam_we, 0);
    chk("r_done", bus.dma_done, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 10; i++) begin
      xfer(tbl[i]);
      if (i == 2) begin
        chk("t3_first", oam[8'hF8], mem[16'h0300]);
        chk("t3_wrap", oam[8'h00], mem[16'h0308]);
        chk("t3_last", last_addr, 8'hF7);
      end
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
